// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared state encoding, port indices and width defaults for the SRAM arbiter
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;
    localparam int NPORT      = 3;

    localparam int PORT_FILL = 0;
    localparam int PORT_WB   = 1;
    localparam int PORT_COMP = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner selection for the SRAM arbiter
//   req : per-port request vector
//   ptr : 0 = port 1 preferred over port 2, 1 = port 2 preferred
//   gnt : one-hot grant (all zero when nothing requests)
// Port 0 always wins; ptr only breaks a tie between ports 1 and 2.
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic             ptr,
    output logic [NPORT-1:0] gnt
);

    assign gnt[PORT_FILL] = req[PORT_FILL];
    assign gnt[PORT_WB]   = ~req[PORT_FILL] & req[PORT_WB] & ~(ptr & req[PORT_COMP]);
    assign gnt[PORT_COMP] = ~req[PORT_FILL] & req[PORT_COMP] & ~(~ptr & req[PORT_WB]);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-port arbiter in front of the sram controller, one transaction at a time
//   i_CLK, i_RST_N             : pixel clock, asynchronous active-low reset
//   i_Req, i_Write             : per-port request (held until o_Ack) and direction (1 = write)
//   i_Addr0..2, i_Data0..2     : per-port word address and write data
//   o_Ack                      : one-hot acceptance pulse, in the request cycle
//   o_RdValid, o_RdData        : one-hot read-return pulse and held read data
//   o_Busy                     : a transaction is in flight
//   o_Begin, o_Write, o_Addr, o_Data_f2s : command to the sram controller
//   i_Ready, i_Data_s2f        : sram controller status and read data
// Macro SRAM_ARB_RR_EN: ports 1 and 2 alternate via a toggling pointer;
// undefined gives fixed priority 0 > 1 > 2.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic [NPORT-1:0]  i_Req,
    input  logic [NPORT-1:0]  i_Write,
    input  logic [ADDR_W-1:0] i_Addr0,
    input  logic [ADDR_W-1:0] i_Addr1,
    input  logic [ADDR_W-1:0] i_Addr2,
    input  logic [DATA_W-1:0] i_Data0,
    input  logic [DATA_W-1:0] i_Data1,
    input  logic [DATA_W-1:0] i_Data2,
    output logic [NPORT-1:0]  o_Ack,
    output logic [NPORT-1:0]  o_RdValid,
    output logic [DATA_W-1:0] o_RdData,
    output logic              o_Busy,
    output logic              o_Begin,
    output logic              o_Write,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [DATA_W-1:0] o_Data_f2s,
    input  logic              i_Ready,
    input  logic [DATA_W-1:0] i_Data_s2f
);

    state_t           state;
    logic             arm;
    logic             waited;
    logic             ptr;
    logic             take;
    logic [NPORT-1:0] gnt;
    logic [NPORT-1:0] owner;

    sram_arb_pick u_pick (
        .req (i_Req),
        .ptr (ptr),
        .gnt (gnt)
    );

    // arm holds off arbitration until the first edge after reset release
    assign take    = state == IDLE && arm && i_Ready && |i_Req;
    assign o_Ack   = take ? gnt : '0;
    assign o_Begin = state == ISSUE && i_Ready;
    assign o_Busy  = state != IDLE;

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge i_CLK or negedge i_RST_N)
        if (!i_RST_N)
            ptr <= 1'b0;
        else if (take && !gnt[PORT_FILL])
            ptr <= ~ptr;
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state      <= IDLE;
            arm        <= 1'b0;
            waited     <= 1'b0;
            owner      <= '0;
            o_Write    <= 1'b0;
            o_Addr     <= '0;
            o_Data_f2s <= '0;
            o_RdData   <= '0;
            o_RdValid  <= '0;
        end else begin
            arm       <= 1'b1;
            o_RdValid <= '0;
            case (state)
                IDLE: if (take) begin
                    state      <= ISSUE;
                    owner      <= gnt;
                    o_Write    <= |(i_Write & gnt);
                    o_Addr     <= gnt[PORT_WB] ? i_Addr1 : gnt[PORT_COMP] ? i_Addr2 : i_Addr0;
                    o_Data_f2s <= gnt[PORT_WB] ? i_Data1 : gnt[PORT_COMP] ? i_Data2 : i_Data0;
                end
                ISSUE: if (i_Ready) begin
                    state  <= BUSY;
                    waited <= 1'b0;
                end
                BUSY: begin
                    // first BUSY cycle is one after o_Begin; exit no sooner than the second
                    waited <= 1'b1;
                    if (waited && i_Ready) begin
                        state <= IDLE;
                        if (!o_Write) begin
                            o_RdData  <= i_Data_s2f;
                            o_RdValid <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
